// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// One operand bit is processed per CALC cycle (shift-add multiply, restoring
// divide on magnitudes). Signs are fixed up when the result is captured on
// entry to DONE. Divide-by-zero and signed overflow skip CALC entirely.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    input  logic [4:0]  rd,
    output logic        busy,
    output logic        done,
    output logic [31:0] wrData,
    output logic [4:0]  wrReg,
    output logic        writeEnable
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    logic [1:0]  r_state;
    logic [4:0]  r_count;
    logic [2:0]  r_funct3;
    logic [4:0]  r_rd;
    logic        r_negate;
    logic        r_negRem;
    logic [63:0] r_acc;
    logic [63:0] r_opX;
    logic [31:0] r_opY;
    logic [31:0] r_wrData;
    logic [4:0]  r_wrReg;

    logic        w_accept;
    logic        w_isDiv;
    logic        w_divSigned;
    logic        w_aSigned;
    logic        w_bSigned;
    logic [31:0] w_magA;
    logic [31:0] w_magB;
    logic        w_negate;
    logic        w_negRem;
    logic        w_divByZero;
    logic        w_overflow;
    logic        w_special;
    logic [31:0] w_specialResult;
    logic [63:0] w_mulAcc;
    logic [32:0] w_shiftRem;
    logic        w_fits;
    logic [31:0] w_diff;
    logic [63:0] w_divAcc;
    logic [63:0] w_accNext;
    logic [63:0] w_product;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [31:0] w_calcResult;
    logic        w_lastCycle;

    // A new request is taken whenever the unit is not iterating
    assign w_accept    = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_lastCycle = (r_state == CALC) && (r_count == 5'd31);

    // Decode the incoming request: operand signedness, magnitudes and special cases
    always_comb begin
        w_isDiv     = funct3[2];
        w_divSigned = ~funct3[0];
        w_aSigned   = 1'b0;
        w_bSigned   = 1'b0;
        if (w_isDiv) begin
            w_aSigned = w_divSigned;
            w_bSigned = w_divSigned;
        end else if (funct3 == F_MULH) begin
            w_aSigned = 1'b1;
            w_bSigned = 1'b1;
        end else if (funct3 == F_MULHSU) begin
            w_aSigned = 1'b1;
        end
        w_magA   = (w_aSigned && opA[31]) ? (~opA + 32'd1) : opA;
        w_magB   = (w_bSigned && opB[31]) ? (~opB + 32'd1) : opB;
        w_negate = (w_aSigned & opA[31]) ^ (w_bSigned & opB[31]);
        w_negRem = w_aSigned & opA[31];

        w_divByZero = w_isDiv && (opB == 32'd0);
        w_overflow  = w_isDiv && w_divSigned && (opA == 32'h8000_0000) &&
                      (opB == 32'hFFFF_FFFF);
        w_special   = w_divByZero || w_overflow;

        w_specialResult = 32'd0;
        if (w_divByZero) begin
            w_specialResult = funct3[1] ? opA : 32'hFFFF_FFFF;
        end else if (w_overflow) begin
            w_specialResult = funct3[1] ? 32'd0 : 32'h8000_0000;
        end
    end

    // One iteration step of either the shift-add multiply or the restoring divide.
    // For divide r_acc holds {remainder, dividend/quotient}; the shifted-out
    // remainder needs 33 bits before the trial subtraction.
    always_comb begin
        w_mulAcc   = r_opY[0] ? (r_acc + r_opX) : r_acc;
        w_shiftRem = r_acc[63:31];
        w_fits     = (w_shiftRem >= {1'b0, r_opY});
        w_diff     = w_shiftRem[31:0] - r_opY;
        w_divAcc   = w_fits ? {w_diff, r_acc[30:0], 1'b1} : {r_acc[62:0], 1'b0};
        w_accNext  = r_funct3[2] ? w_divAcc : w_mulAcc;
    end

    // Sign correction and result selection from the final iteration's value
    always_comb begin
        w_product = r_negate ? (~w_accNext + 64'd1) : w_accNext;
        w_quot    = r_negate ? (~w_accNext[31:0] + 32'd1) : w_accNext[31:0];
        w_rem     = r_negRem ? (~w_accNext[63:32] + 32'd1) : w_accNext[63:32];
        case (r_funct3)
            F_MUL:                      w_calcResult = w_product[31:0];
            F_MULH, F_MULHSU, F_MULHU:  w_calcResult = w_product[63:32];
            F_DIV, F_DIVU:              w_calcResult = w_quot;
            F_REM, F_REMU:              w_calcResult = w_rem;
            default:                    w_calcResult = 32'd0;
        endcase
    end

    // Control FSM and iteration counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_count <= 5'd0;
        end else if (w_accept) begin
            r_state <= w_special ? DONE : CALC;
            r_count <= 5'd0;
        end else begin
            case (r_state)
                CALC: begin
                    r_count <= r_count + 5'd1;
                    if (w_lastCycle) begin
                        r_state <= DONE;
                    end
                end
                DONE:    r_state <= IDLE;
                IDLE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Latch the request and step the multiply/divide datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_funct3 <= 3'd0;
            r_rd     <= 5'd0;
            r_negate <= 1'b0;
            r_negRem <= 1'b0;
            r_acc    <= 64'd0;
            r_opX    <= 64'd0;
            r_opY    <= 32'd0;
        end else if (w_accept) begin
            r_funct3 <= funct3;
            r_rd     <= rd;
            r_negate <= w_negate;
            r_negRem <= w_negRem;
            r_opY    <= w_magB;
            if (w_isDiv) begin
                r_acc <= {32'd0, w_magA};
                r_opX <= 64'd0;
            end else begin
                r_acc <= 64'd0;
                r_opX <= {32'd0, w_magA};
            end
        end else if (r_state == CALC) begin
            r_acc <= w_accNext;
            if (!r_funct3[2]) begin
                r_opX <= {r_opX[62:0], 1'b0};
                r_opY <= {1'b0, r_opY[31:1]};
            end
        end
    end

    // Result registers change only on the edge that enters DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wrData <= 32'd0;
            r_wrReg  <= 5'd0;
        end else if (w_accept && w_special) begin
            r_wrData <= w_specialResult;
            r_wrReg  <= rd;
        end else if (w_lastCycle) begin
            r_wrData <= w_calcResult;
            r_wrReg  <= r_rd;
        end
    end

    assign busy        = (r_state == CALC);
    assign done        = (r_state == DONE);
    assign wrData      = r_wrData;
    assign wrReg       = r_wrReg;
    assign writeEnable = done && (r_wrReg != 5'd0);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;

   localparam logic [2:0] F_MUL    = 3'b000;
   localparam logic [2:0] F_MULH   = 3'b001;
   localparam logic [2:0] F_MULHSU = 3'b010;
   localparam logic [2:0] F_MULHU  = 3'b011;
   localparam logic [2:0] F_DIV    = 3'b100;
   localparam logic [2:0] F_DIVU   = 3'b101;
   localparam logic [2:0] F_REM    = 3'b110;
   localparam logic [2:0] F_REMU   = 3'b111;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  funct3 = 3'd0;
   logic [31:0] opA = 32'd0;
   logic [31:0] opB = 32'd0;
   logic [4:0]  rd = 5'd0;
   logic        busy;
   logic        done;
   logic [31:0] wrData;
   logic [4:0]  wrReg;
   logic        writeEnable;

   int compared = 0;
   int mismatched = 0;

   typedef struct {
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          cyc;
   } vec_t;

   muldiv_unit dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .funct3      (funct3),
      .opA         (opA),
      .opB         (opB),
      .rd          (rd),
      .busy        (busy),
      .done        (done),
      .wrData      (wrData),
      .wrReg       (wrReg),
      .writeEnable (writeEnable)
   );

   always #5 clk = ~clk;

   // Present a request for one edge; afterwards the bench sits 1ns into cycle 1
   // and the request inputs are scrambled so only latched values can matter.
   task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d, input bit keepStart);
      start  = 1'b1;
      funct3 = f;
      opA    = a;
      opB    = b;
      rd     = d;
      @(posedge clk);
      #1;
      if (!keepStart) start = 1'b0;
      funct3 = 3'($urandom);
      opA    = $urandom;
      opB    = $urandom;
      rd     = 5'($urandom);
   endtask

   // Step cycles until done is seen; returns the cycle index or -1 after a timeout
   task automatic waitDone(input int firstCyc, output int cyc, output int busyCnt);
      cyc = firstCyc;
      busyCnt = 0;
      while (!done && cyc < 80) begin
         if (busy) busyCnt++;
         @(posedge clk);
         #1;
         cyc++;
      end
      if (!done) cyc = -1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
      compared++; if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done got %b want 0", done); end
      compared++; if (writeEnable !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_we got %b want 0", writeEnable); end
      compared++; if (wrData !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_wrData got %h want 0", wrData); end
      compared++; if (wrReg !== 5'd0) begin mismatched++; $display("[TB] FAIL reset_wrReg got %0d want 0", wrReg); end
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_mul();
      int cyc, busyCnt;
      launch(F_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b0);
      waitDone(1, cyc, busyCnt);
      compared++; if (cyc !== 33) begin mismatched++; $display("[TB] FAIL mul_done_cycle got %0d want 33", cyc); end
      compared++; if (busyCnt !== 32) begin mismatched++; $display("[TB] FAIL mul_busy_cycles got %0d want 32", busyCnt); end
      compared++; if (wrData !== 32'hFFFF_FFEB) begin mismatched++; $display("[TB] FAIL mul_wrData got %h want ffffffeb", wrData); end
      compared++; if (wrReg !== 5'd5) begin mismatched++; $display("[TB] FAIL mul_wrReg got %0d want 5", wrReg); end
      compared++; if (writeEnable !== 1'b1) begin mismatched++; $display("[TB] FAIL mul_we got %b want 1", writeEnable); end
      @(posedge clk);
      #1;
      compared++; if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL mul_done_after got %b want 0", done); end
      compared++; if (writeEnable !== 1'b0) begin mismatched++; $display("[TB] FAIL mul_we_after got %b want 0", writeEnable); end
      compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL mul_busy_after got %b want 0", busy); end
      compared++; if (wrData !== 32'hFFFF_FFEB) begin mismatched++; $display("[TB] FAIL mul_hold got %h want ffffffeb", wrData); end
   endtask

   task automatic test_mul_high();
      vec_t v[3];
      int cyc, busyCnt;
      v[0] = '{F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
      v[1] = '{F_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33};
      v[2] = '{F_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33};
      for (int i = 0; i < 3; i++) begin
         launch(v[i].f, v[i].a, v[i].b, 5'd10, 1'b0);
         waitDone(1, cyc, busyCnt);
         compared++; if (cyc !== v[i].cyc) begin mismatched++; $display("[TB] FAIL mulh_cycle[%0d] got %0d want %0d", i, cyc, v[i].cyc); end
         compared++; if (wrData !== v[i].exp) begin mismatched++; $display("[TB] FAIL mulh_wrData[%0d] got %h want %h", i, wrData, v[i].exp); end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_divide();
      vec_t v[4];
      int cyc, busyCnt;
      v[0] = '{F_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33};
      v[1] = '{F_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33};
      v[2] = '{F_DIVU, 32'd100,       32'd7, 32'd14,        33};
      v[3] = '{F_REMU, 32'd100,       32'd7, 32'd2,         33};
      for (int i = 0; i < 4; i++) begin
         launch(v[i].f, v[i].a, v[i].b, 5'd11, 1'b0);
         waitDone(1, cyc, busyCnt);
         compared++; if (cyc !== v[i].cyc) begin mismatched++; $display("[TB] FAIL div_cycle[%0d] got %0d want %0d", i, cyc, v[i].cyc); end
         compared++; if (wrData !== v[i].exp) begin mismatched++; $display("[TB] FAIL div_wrData[%0d] got %h want %h", i, wrData, v[i].exp); end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_special();
      vec_t v[4];
      int cyc, busyCnt;
      v[0] = '{F_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
      v[1] = '{F_REMU, 32'd5,         32'd0,         32'd5,         1};
      v[2] = '{F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
      v[3] = '{F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};
      for (int i = 0; i < 4; i++) begin
         launch(v[i].f, v[i].a, v[i].b, 5'd12, 1'b0);
         waitDone(1, cyc, busyCnt);
         compared++; if (cyc !== v[i].cyc) begin mismatched++; $display("[TB] FAIL special_cycle[%0d] got %0d want %0d", i, cyc, v[i].cyc); end
         compared++; if (wrData !== v[i].exp) begin mismatched++; $display("[TB] FAIL special_wrData[%0d] got %h want %h", i, wrData, v[i].exp); end
         compared++; if (wrReg !== 5'd12) begin mismatched++; $display("[TB] FAIL special_wrReg[%0d] got %0d want 12", i, wrReg); end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_ignore_start();
      int cyc, busyCnt;
      launch(F_DIVU, 32'd100, 32'd7, 5'd3, 1'b0);
      repeat (9) begin
         @(posedge clk);
         #1;
      end
      start  = 1'b1;
      funct3 = F_MUL;
      opA    = 32'd2;
      opB    = 32'd2;
      rd     = 5'd9;
      @(posedge clk);
      #1;
      start = 1'b0;
      compared++; if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL ignore_busy got %b want 1", busy); end
      waitDone(11, cyc, busyCnt);
      compared++; if (cyc !== 33) begin mismatched++; $display("[TB] FAIL ignore_cycle got %0d want 33", cyc); end
      compared++; if (wrData !== 32'd14) begin mismatched++; $display("[TB] FAIL ignore_wrData got %h want 0000000e", wrData); end
      compared++; if (wrReg !== 5'd3) begin mismatched++; $display("[TB] FAIL ignore_wrReg got %0d want 3", wrReg); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back();
      int cyc, busyCnt;
      launch(F_MUL, 32'd3, 32'd4, 5'd7, 1'b1);
      funct3 = F_DIVU;
      opA    = 32'd100;
      opB    = 32'd7;
      rd     = 5'd8;
      waitDone(1, cyc, busyCnt);
      compared++; if (cyc !== 33) begin mismatched++; $display("[TB] FAIL b2b_first_cycle got %0d want 33", cyc); end
      compared++; if (wrData !== 32'd12) begin mismatched++; $display("[TB] FAIL b2b_first_wrData got %h want 0000000c", wrData); end
      compared++; if (writeEnable !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_first_we got %b want 1", writeEnable); end
      @(posedge clk);
      #1;
      start = 1'b0;
      compared++; if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_second_busy got %b want 1", busy); end
      compared++; if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_second_done got %b want 0", done); end
      waitDone(1, cyc, busyCnt);
      compared++; if (cyc !== 33) begin mismatched++; $display("[TB] FAIL b2b_second_cycle got %0d want 33", cyc); end
      compared++; if (wrData !== 32'd14) begin mismatched++; $display("[TB] FAIL b2b_second_wrData got %h want 0000000e", wrData); end
      compared++; if (wrReg !== 5'd8) begin mismatched++; $display("[TB] FAIL b2b_second_wrReg got %0d want 8", wrReg); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid();
      int cyc, busyCnt, doneCnt;
      launch(F_MUL, 32'd7, 32'd9, 5'd4, 1'b0);
      repeat (14) begin
         @(posedge clk);
         #1;
      end
      #2;
      rst = 1'b0;
      #1;
      compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_busy got %b want 0", busy); end
      compared++; if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_done got %b want 0", done); end
      compared++; if (writeEnable !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_we got %b want 0", writeEnable); end
      compared++; if (wrData !== 32'd0) begin mismatched++; $display("[TB] FAIL abort_wrData got %h want 0", wrData); end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      doneCnt = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done || writeEnable) doneCnt++;
      end
      compared++; if (doneCnt !== 0) begin mismatched++; $display("[TB] FAIL abort_no_completion got %0d want 0", doneCnt); end
      launch(F_MUL, 32'd2, 32'd3, 5'd0, 1'b0);
      waitDone(1, cyc, busyCnt);
      compared++; if (cyc !== 33) begin mismatched++; $display("[TB] FAIL rd0_cycle got %0d want 33", cyc); end
      compared++; if (wrData !== 32'd6) begin mismatched++; $display("[TB] FAIL rd0_wrData got %h want 00000006", wrData); end
      compared++; if (writeEnable !== 1'b0) begin mismatched++; $display("[TB] FAIL rd0_we got %b want 0", writeEnable); end
      @(posedge clk);
      #1;
   endtask

   // Guard against a hung design
   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout got hang want finish");
      $fatal(1, "[TB] watchdog");
   end

   // Run every scenario in order and report
   initial begin
      test_reset();
      test_mul();
      test_mul_high();
      test_divide();
      test_special();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
